// File: rtl/e203_ifu_flush_rcv.sv
// e203_ifu_flush_rcv: fetch-side branch-mispredict flush receiver with fetch drain and redirect handoff
module e203_ifu_flush_rcv #(
    parameter int PC_SIZE    = 32,
    parameter int OUTS_DEPTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               brchmis_flush_req,
    input  logic [PC_SIZE-1:0] brchmis_flush_add_op1,
    input  logic [PC_SIZE-1:0] brchmis_flush_add_op2,
    output logic               brchmis_flush_ack,
    input  logic               ifu_req_valid_i,
    output logic               ifu_req_valid_o,
    input  logic               ifu_req_ready,
    input  logic               ifu_rsp_valid,
    input  logic               ifu_rsp_ready,
    output logic               ifu_rsp_kill,
    output logic               pipe_flush_vld,
    output logic [PC_SIZE-1:0] pipe_flush_pc,
    input  logic               pipe_flush_rdy,
    output logic               flush_pending
);
    localparam int CW = $clog2(OUTS_DEPTH + 1);
    localparam logic [CW-1:0] OUTS_MAX = CW'(OUTS_DEPTH);
    typedef enum logic [1:0] {IDLE, DRAIN, REDIR} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      outs_cnt_q, outs_cnt_d;
    logic [CW-1:0]      kill_cnt_q, kill_cnt_d;
    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic [PC_SIZE-1:0] tgt;
    logic               req_hsk, rsp_hsk;
    assign tgt               = brchmis_flush_add_op1 + brchmis_flush_add_op2;
    assign brchmis_flush_ack = brchmis_flush_req & (state_q == IDLE) & (outs_cnt_q == '0);
    assign ifu_req_valid_o   = ifu_req_valid_i & ~brchmis_flush_req & (state_q == IDLE) & (outs_cnt_q != OUTS_MAX);
    assign ifu_rsp_kill      = (state_q == DRAIN) & ifu_rsp_valid;
    assign pipe_flush_vld    = state_q == REDIR;
    assign flush_pending     = state_q != IDLE;
    assign pipe_flush_pc     = pc_q;
    assign req_hsk           = ifu_req_valid_o & ifu_req_ready;
    assign rsp_hsk           = ifu_rsp_valid & ifu_rsp_ready & (outs_cnt_q != '0);
    // outstanding fetch count: request and response in the same cycle cancel out
    always_comb begin
        outs_cnt_d = outs_cnt_q + CW'(req_hsk) - CW'(rsp_hsk);
    end
    // flush control: ack when drained, kill stale responses, hold redirect until taken
    always_comb begin
        state_d    = state_q;
        kill_cnt_d = kill_cnt_q;
        pc_d       = pc_q;
        case (state_q)
            IDLE: begin
                if (brchmis_flush_ack) begin
                    pc_d    = {tgt[PC_SIZE-1:1], 1'b0};
                    state_d = REDIR;
                end else if (brchmis_flush_req) begin
                    kill_cnt_d = outs_cnt_q;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                kill_cnt_d = kill_cnt_q - CW'(rsp_hsk);
                state_d    = (kill_cnt_d == '0) ? IDLE : DRAIN;
            end
            REDIR: state_d = pipe_flush_rdy ? IDLE : REDIR;
            default: state_d = IDLE;
        endcase
    end
    // state, counters and redirect PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            outs_cnt_q <= '0;
            kill_cnt_q <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            outs_cnt_q <= outs_cnt_d;
            kill_cnt_q <= kill_cnt_d;
            pc_q       <= pc_d;
        end
    end
    rsp_without_req: assert property (@(posedge clk) disable iff (rst)
        !(ifu_rsp_valid && ifu_rsp_ready && outs_cnt_q == '0));
endmodule

// File: tb/tb_e203_ifu_flush_rcv.sv
// tb_e203_ifu_flush_rcv: table-driven and randomized checks of the flush receiver
module tb_e203_ifu_flush_rcv;
    logic        clk = 0;
    logic        rst;
    logic        fr, rvi, rrdy, rspv, rspr, prdy;
    logic [31:0] op1, op2;
    logic        ack, rvo, kill, vld, pend;
    logic [31:0] pc;
    int          nvec = 0;
    int          nmis = 0;

    typedef struct {
        logic        fr, rvi, rrdy, rspv, rspr, prdy;
        logic [31:0] op1, op2;
        logic        ack, rvo, kill, vld, pend;
        logic [31:0] pc;
    } vec_t;

    e203_ifu_flush_rcv #(.PC_SIZE(32), .OUTS_DEPTH(1)) dut (
        .clk(clk), .rst(rst),
        .brchmis_flush_req(fr), .brchmis_flush_add_op1(op1), .brchmis_flush_add_op2(op2),
        .brchmis_flush_ack(ack),
        .ifu_req_valid_i(rvi), .ifu_req_valid_o(rvo), .ifu_req_ready(rrdy),
        .ifu_rsp_valid(rspv), .ifu_rsp_ready(rspr), .ifu_rsp_kill(kill),
        .pipe_flush_vld(vld), .pipe_flush_pc(pc), .pipe_flush_rdy(prdy),
        .flush_pending(pend)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [5:0] in, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] out, input logic [31:0] p);
        vec_t t;
        {t.fr, t.rvi, t.rrdy, t.rspv, t.rspr, t.prdy} = in;
        t.op1 = a;
        t.op2 = b;
        {t.ack, t.rvo, t.kill, t.vld, t.pend} = out;
        t.pc = p;
        return t;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic drive(input vec_t t);
        fr = t.fr; rvi = t.rvi; rrdy = t.rrdy; rspv = t.rspv; rspr = t.rspr; prdy = t.prdy;
        op1 = t.op1; op2 = t.op2;
    endtask

    task automatic check_all(input vec_t t, input string tag);
        chk({tag, " ack"}, 32'(ack), 32'(t.ack));
        chk({tag, " req_valid_o"}, 32'(rvo), 32'(t.rvo));
        chk({tag, " rsp_kill"}, 32'(kill), 32'(t.kill));
        chk({tag, " flush_vld"}, 32'(vld), 32'(t.vld));
        chk({tag, " pending"}, 32'(pend), 32'(t.pend));
        chk({tag, " flush_pc"}, pc, t.pc);
    endtask

    task automatic run(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
        check_all(t, tag);
    endtask

    vec_t        tbl[$];
    int          outs, kill_left;
    bit          draining, redir, idle, rsp_h, req_h;
    logic [31:0] rpc;

    initial begin
        rst = 1;
        drive(v(6'b000000, 0, 0, 5'b00000, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all(v(6'b000000, 0, 0, 5'b00000, 0), "reset");
        @(posedge clk);
        #1 rst = 0;

        // inputs {fr,rvi,rrdy,rspv,rspr,prdy}; outputs {ack,rvo,kill,vld,pend}
        tbl.push_back(v(6'b110000, 32'h80000100, 32'h4, 5'b10000, 32'h0));
        tbl.push_back(v(6'b010001, 0, 0, 5'b00011, 32'h80000104));
        tbl.push_back(v(6'b011000, 0, 0, 5'b01000, 32'h80000104));
        tbl.push_back(v(6'b111000, 32'h1000, 32'h20, 5'b00000, 32'h80000104));
        tbl.push_back(v(6'b111100, 32'h1000, 32'h20, 5'b00101, 32'h80000104));
        tbl.push_back(v(6'b111000, 32'h1000, 32'h20, 5'b00001, 32'h80000104));
        tbl.push_back(v(6'b110110, 32'h1000, 32'h20, 5'b00101, 32'h80000104));
        tbl.push_back(v(6'b110000, 32'h1000, 32'h20, 5'b10000, 32'h80000104));
        tbl.push_back(v(6'b000001, 0, 0, 5'b00011, 32'h1020));
        tbl.push_back(v(6'b100000, 32'hFFFFFFFE, 32'h5, 5'b10000, 32'h1020));
        tbl.push_back(v(6'b000001, 0, 0, 5'b00011, 32'h2));
        tbl.push_back(v(6'b011000, 0, 0, 5'b01000, 32'h2));
        tbl.push_back(v(6'b111000, 32'h40, 32'h40, 5'b00000, 32'h2));
        tbl.push_back(v(6'b011000, 0, 0, 5'b00001, 32'h2));
        tbl.push_back(v(6'b000110, 0, 0, 5'b00101, 32'h2));
        tbl.push_back(v(6'b000000, 0, 0, 5'b00000, 32'h2));
        tbl.push_back(v(6'b000001, 0, 0, 5'b00000, 32'h2));
        tbl.push_back(v(6'b100000, 32'h2000, 32'h10, 5'b10000, 32'h2));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(6'b100000, 32'h3000, 32'h8, 5'b00011, 32'h2010));
        tbl.push_back(v(6'b100001, 32'h3000, 32'h8, 5'b00011, 32'h2010));
        tbl.push_back(v(6'b100000, 32'h3000, 32'h8, 5'b10000, 32'h2010));
        tbl.push_back(v(6'b000001, 0, 0, 5'b00011, 32'h3008));
        tbl.push_back(v(6'b011000, 0, 0, 5'b01000, 32'h3008));
        tbl.push_back(v(6'b010110, 0, 0, 5'b00000, 32'h3008));
        tbl.push_back(v(6'b010000, 0, 0, 5'b01000, 32'h3008));
        tbl.push_back(v(6'b011000, 0, 0, 5'b01000, 32'h3008));
        tbl.push_back(v(6'b100000, 32'h50, 32'h50, 5'b00000, 32'h3008));
        tbl.push_back(v(6'b100000, 32'h50, 32'h50, 5'b00001, 32'h3008));
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        @(posedge clk);
        #1;
        rst = 1;
        drive(v(6'b000000, 0, 0, 5'b00000, 0));
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_all(v(6'b000000, 0, 0, 5'b00000, 0), "post_reset");
        run(v(6'b010100, 0, 0, 5'b01000, 0), "post_reset_cnt");

        outs = 0; kill_left = 0; draining = 0; redir = 0; rpc = 0;
        for (int i = 0; i < 1500; i++) begin
            vec_t t;
            t.fr   = ($urandom_range(3) == 0);
            t.op1  = $urandom;
            t.op2  = $urandom;
            t.rvi  = 1'($urandom);
            t.rrdy = 1'($urandom);
            t.rspv = 1'($urandom);
            t.rspr = (outs > 0) ? 1'($urandom) : 1'b0;
            t.prdy = 1'($urandom);
            idle   = !draining && !redir;
            t.ack  = t.fr && idle && outs == 0;
            t.rvo  = t.rvi && !t.fr && idle && outs < 1;
            t.kill = draining && t.rspv;
            t.vld  = redir;
            t.pend = !idle;
            t.pc   = rpc;
            run(t, "rnd");
            rsp_h = t.rspv && t.rspr;
            req_h = t.rvo && t.rrdy;
            if (draining) begin
                if (rsp_h) begin
                    kill_left--;
                    if (kill_left == 0) draining = 0;
                end
            end else if (redir) begin
                if (t.prdy) redir = 0;
            end else if (t.ack) begin
                redir = 1;
                rpc = (t.op1 + t.op2) & ~32'h1;
            end else if (t.fr) begin
                draining = 1;
                kill_left = outs;
            end
            outs = outs + int'(req_h) - int'(rsp_h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
